spi_cfg_regfile: RTL and testbench

Addressed SPI configuration register file for the FM transmitter. It replaces the flat config shift chain with a command/address/data protocol, so each field can be written, read back and committed atomically. Byte-write sequencing, multi-byte shadow commits and pin/SPI override muxing all happen in the spi_clk domain. Its outputs drive the phase accumulator, the deviation scaler, the DAC enables, the dither and the audio input selection.

---
 rtl/spi_cfg_regfile_if.sv | 10 +
 rtl/spi_cfg_regfile.sv | 179 +++++++++++++++++
 tb/tb_spi_cfg_regfile.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_regfile_if.sv
// Serial configuration bus: the master drives frame select and MOSI,
// the register file answers on MISO.
interface spi_cfg_regfile_if;
  logic spi_csn;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_csn, output spi_mosi, input spi_miso);
  modport slave  (input spi_csn, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_cfg_regfile.sv
// Addressed SPI configuration register file for the FM transmitter: command/address/data
// frames with byte bursts, shadowed multi-byte commits and pin/SPI override muxing.
module spi_cfg_regfile #(
  parameter int             N             = 18,
  parameter int             L             = 12,
  parameter int             D             = 5,
  parameter logic [N-1:0]   ACC_INC_DEF   = 18'h0CCCC,
  parameter logic [L-1:0]   DF_INC_DEF    = 12'h189,
  parameter logic [2:0]     DITH_FACT_DEF = 3'd2,
  parameter logic [7:0]     CHIP_ID       = 8'hA5
) (
  input  logic              rst,
  input  logic              spi_clk,
  spi_cfg_regfile_if.slave  spi,
  input  logic              usb_i2sn_pin,
  input  logic              audio_chan_sel_pin,
  input  logic              i2s_ws_align_pin,
  input  logic              dith_disable_pin,
  output logic [N-1:0]      acc_inc,
  output logic [L-1:0]      df_inc,
  output logic [D-1:0]      dac_ena,
  output logic [2:0]        dith_fact,
  output logic              usb_i2sn,
  output logic              audio_chan_sel,
  output logic              i2s_ws_align,
  output logic              cfg_update
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

  state_e      st_q, st_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [6:0]  sr_q, sr_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic        halt_q;
  logic        miso_q;
  logic        frm_rst;
  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        wr_stb;
  logic [2:0]  bit_idx;

  logic [7:0]  sh0_q, sh1_q, sh3_q, ctrl_q;
  logic [N-1:0] acc_q;
  logic [L-1:0] df_q;
  logic [D-1:0] dac_q;
  logic        cfg_upd_q;

  assign frm_rst   = rst | spi.spi_csn;
  assign rx_byte   = {sr_q, spi.spi_mosi};
  assign byte_done = (cnt_q == 5'd15);
  assign wr_stb    = (st_q == WDATA) && byte_done && !halt_q;
  assign bit_idx   = ~cnt_q[2:0];

  function automatic logic [7:0] rd_byte(input logic [6:0] a);
    logic [7:0] r;
    r = '0;
    case (a)
      7'h00:   r = sh0_q;
      7'h01:   r = sh1_q;
      7'h02:   r[N-17:0] = acc_q[N-1:16];
      7'h03:   r = sh3_q;
      7'h04:   r[L-9:0] = df_q[L-1:8];
      7'h05:   r[D-1:0] = dac_q;
      7'h06:   r = ctrl_q;
      7'h07:   r = CHIP_ID;
      default: r = '0;
    endcase
    return r;
  endfunction

  // A reset that lands inside a frame freezes the decoder until frame select is released.
  always_ff @(posedge rst or posedge spi.spi_csn) begin
    if (spi.spi_csn) halt_q <= 1'b0;
    else             halt_q <= 1'b1;
  end

  // Counter runs 1..16 over command+first byte, then 9..16 for every burst byte.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    addr_d = addr_q;
    tx_d   = tx_q;
    if (!halt_q) begin
      sr_d  = rx_byte[6:0];
      cnt_d = (cnt_q == 5'd16) ? 5'd9 : cnt_q + 5'd1;
      case (st_q)
        IDLE: st_d = CMD;
        CMD: begin
          if (cnt_q == 5'd7) begin
            st_d   = rx_byte[7] ? RDATA : WDATA;
            addr_d = rx_byte[6:0];
            tx_d   = rd_byte(rx_byte[6:0]);
          end
        end
        default: begin
          if (byte_done) begin
            addr_d = addr_q + 7'd1;
            tx_d   = rd_byte(addr_q + 7'd1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge spi_clk or posedge frm_rst) begin
    if (frm_rst) begin
      st_q  <= IDLE;
      cnt_q <= 5'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge spi_clk) begin
    sr_q   <= sr_d;
    addr_q <= addr_d;
    tx_q   <= tx_d;
  end

  // MISO launches on the falling edge so the master samples it on the next rising edge.
  always_ff @(negedge spi_clk or posedge frm_rst) begin
    if (frm_rst) miso_q <= 1'b0;
    else         miso_q <= (st_q == RDATA) && tx_q[bit_idx];
  end

  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      sh0_q     <= ACC_INC_DEF[7:0];
      sh1_q     <= ACC_INC_DEF[15:8];
      sh3_q     <= DF_INC_DEF[7:0];
      acc_q     <= ACC_INC_DEF;
      df_q      <= DF_INC_DEF;
      dac_q     <= '1;
      ctrl_q    <= {5'd0, DITH_FACT_DEF};
      cfg_upd_q <= 1'b0;
    end else begin
      cfg_upd_q <= 1'b0;
      if (wr_stb) begin
        case (addr_q)
          7'h00: sh0_q <= rx_byte;
          7'h01: sh1_q <= rx_byte;
          7'h02: begin
            acc_q     <= {rx_byte[N-17:0], sh1_q, sh0_q};
            cfg_upd_q <= 1'b1;
          end
          7'h03: sh3_q <= rx_byte;
          7'h04: begin
            df_q      <= {rx_byte[L-9:0], sh3_q};
            cfg_upd_q <= 1'b1;
          end
          7'h05: begin
            dac_q     <= rx_byte[D-1:0];
            cfg_upd_q <= 1'b1;
          end
          7'h06: begin
            ctrl_q    <= rx_byte & 8'hBF;
            cfg_upd_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign spi.spi_miso   = miso_q;
  assign acc_inc        = acc_q;
  assign df_inc         = df_q;
  assign dac_ena        = dac_q;
  assign cfg_update     = cfg_upd_q;
  assign usb_i2sn       = ctrl_q[7] ? ctrl_q[3] : usb_i2sn_pin;
  assign audio_chan_sel = ctrl_q[7] ? ctrl_q[4] : audio_chan_sel_pin;
  assign i2s_ws_align   = ctrl_q[7] ? ctrl_q[5] : i2s_ws_align_pin;
  assign dith_fact      = (ctrl_q[7] || !dith_disable_pin) ? ctrl_q[2:0] : 3'd0;

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// Scoreboard bench for spi_cfg_regfile: a driver issues SPI frames and queues expectations
// from a register-map model; monitors decode MISO bytes and cfg_update pulses independently.
`timescale 1ns/1ps
module tb_spi_cfg_regfile;
  localparam int N = 18, L = 12, D = 5;

  typedef struct packed {
    logic [17:0] acc;
    logic [11:0] df;
    logic [4:0]  dac;
    logic [2:0]  dith;
    logic        usb;
    logic        chan;
    logic        ws;
  } outs_t;

  logic rst, spi_clk;
  logic usb_pin, chan_pin, ws_pin, dd_pin;
  logic [N-1:0] acc_inc;
  logic [L-1:0] df_inc;
  logic [D-1:0] dac_ena;
  logic [2:0]   dith_fact;
  logic usb_i2sn, audio_chan_sel, i2s_ws_align, cfg_update;

  spi_cfg_regfile_if bus();

  spi_cfg_regfile dut (
    .rst(rst), .spi_clk(spi_clk), .spi(bus),
    .usb_i2sn_pin(usb_pin), .audio_chan_sel_pin(chan_pin),
    .i2s_ws_align_pin(ws_pin), .dith_disable_pin(dd_pin),
    .acc_inc(acc_inc), .df_inc(df_inc), .dac_ena(dac_ena), .dith_fact(dith_fact),
    .usb_i2sn(usb_i2sn), .audio_chan_sel(audio_chan_sel), .i2s_ws_align(i2s_ws_align),
    .cfg_update(cfg_update)
  );

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rd_q[$];
  outs_t      upd_q[$];
  logic [7:0] wbuf [16];

  // Register-map model
  logic [7:0]  m_sh0, m_sh1, m_sh3, m_ctrl;
  logic [17:0] m_acc;
  logic [11:0] m_df;
  logic [4:0]  m_dac;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name, string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endfunction

  function automatic void model_reset();
    m_acc = 18'h0CCCC; m_df = 12'h189; m_dac = 5'h1F; m_ctrl = 8'h02;
    m_sh0 = 8'hCC; m_sh1 = 8'hCC; m_sh3 = 8'h89;
  endfunction

  function automatic bit model_write(int a, logic [7:0] d);
    bit upd = 1'b0;
    case (a)
      0: m_sh0 = d;
      1: m_sh1 = d;
      2: begin m_acc = 18'((d % 4) * 65536 + m_sh1 * 256 + m_sh0); upd = 1'b1; end
      3: m_sh3 = d;
      4: begin m_df = 12'((d % 16) * 256 + m_sh3); upd = 1'b1; end
      5: begin m_dac = 5'(d % 32); upd = 1'b1; end
      6: begin m_ctrl = d & 8'hBF; upd = 1'b1; end
      default: ;
    endcase
    return upd;
  endfunction

  function automatic logic [7:0] model_read(int a);
    case (a)
      0: return m_sh0;
      1: return m_sh1;
      2: return 8'(m_acc / 65536);
      3: return m_sh3;
      4: return 8'(m_df / 256);
      5: return 8'(m_dac);
      6: return m_ctrl;
      7: return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  function automatic outs_t model_outs();
    outs_t o;
    bit ovr;
    ovr    = m_ctrl[7];
    o.acc  = m_acc;
    o.df   = m_df;
    o.dac  = m_dac;
    o.dith = (ovr || !dd_pin) ? m_ctrl[2:0] : 3'd0;
    o.usb  = ovr ? m_ctrl[3] : usb_pin;
    o.chan = ovr ? m_ctrl[4] : chan_pin;
    o.ws   = ovr ? m_ctrl[5] : ws_pin;
    return o;
  endfunction

  function automatic outs_t dut_outs();
    return {acc_inc, df_inc, dac_ena, dith_fact, usb_i2sn, audio_chan_sel, i2s_ws_align};
  endfunction

  function automatic void check_outs(string name);
    check(name, dut_outs(), model_outs());
  endfunction

  function automatic logic frame_bit(bit rd, int addr, int k);
    logic [6:0] a;
    logic [7:0] b;
    a = 7'(addr);
    if (k == 1) return rd;
    if (k <= 8) return a[8-k];
    b = wbuf[(k-9)/8];
    return b[7 - ((k-9) % 8)];
  endfunction

  // One frame: stop_at>0 raises csn after that many bits; rst_at>0 pulses rst after that bit.
  task automatic spi_frame(input bit rd, input int addr, input int nbytes,
                           input int stop_at, input int rst_at);
    int total, ncomp;
    bit halted;
    total = 8 + 8 * nbytes;
    if (stop_at > 0 && stop_at < total) total = stop_at;
    ncomp  = (total >= 16) ? (total - 8) / 8 : 0;
    halted = 1'b0;
    if (rd) for (int j = 0; j < ncomp; j++) rd_q.push_back(model_read((addr + j) % 128));
    @(negedge spi_clk);
    bus.spi_csn  = 1'b0;
    bus.spi_mosi = frame_bit(rd, addr, 1);
    for (int k = 1; k <= total; k++) begin
      @(posedge spi_clk);
      #1;
      if (!rd && k >= 16 && k % 8 == 0) begin
        int j = k / 8 - 2;
        if (!halted && model_write((addr + j) % 128, wbuf[j])) upd_q.push_back(model_outs());
        check_outs($sformatf("wr_byte%0d_outs", j));
      end
      @(negedge spi_clk);
      if (k == rst_at) begin
        rst = 1'b1;
        halted = 1'b1;
        model_reset();
        upd_q.delete();
        rd_q.delete();
        #1 check_outs("rst_mid_frame_outs");
        check("rst_mid_frame_miso", bus.spi_miso, 0);
      end
      if (rst_at > 0 && k == rst_at + 2) rst = 1'b0;
      bus.spi_mosi = (k < total) ? frame_bit(rd, addr, k + 1) : 1'b0;
    end
    bus.spi_csn  = 1'b1;
    bus.spi_mosi = 1'b0;
    #1 check("miso_after_csn", bus.spi_miso, 0);
    repeat (2) @(negedge spi_clk);
    check("upd_pending", upd_q.size(), 0);
    check("rd_pending", rd_q.size(), 0);
    check_outs("frame_end_outs");
  endtask

  // MISO monitor: decodes frames from the bus and checks each completed read byte.
  initial begin : miso_mon
    int  n;
    bit  rdf, halt, bad;
    logic [7:0] sh;
    n = 0; rdf = 1'b0; halt = 1'b0; bad = 1'b0; sh = 8'h00;
    forever begin
      @(posedge spi_clk);
      if (bus.spi_csn) begin
        n = 0; halt = 1'b0;
      end else if (rst) begin
        n = 0; halt = 1'b1;
      end else if (!halt) begin
        n++;
        if (n == 1) begin rdf = bus.spi_mosi; bad = 1'b0; end
        if (n <= 8 || !rdf) bad = bad | (bus.spi_miso !== 1'b0);
        if (n == 8 || (!rdf && n > 8 && n % 8 == 0)) check("miso_quiet", bad, 0);
        if (rdf && n > 8) begin
          sh = {sh[6:0], bus.spi_miso};
          if (n % 8 == 0) begin
            if (rd_q.size() == 0) fail("rd_unexpected", $sformatf("got 0x%0h, want no byte", sh));
            else check("rd_byte", sh, rd_q.pop_front());
          end
        end
      end
    end
  end

  // cfg_update monitor: every pulse must match a queued commit and its resulting outputs.
  initial begin : upd_mon
    forever begin
      @(negedge spi_clk);
      if (cfg_update === 1'b1) begin
        if (upd_q.size() == 0) fail("cfg_update_unexpected", "got pulse, want none");
        else check("cfg_update_outs", dut_outs(), upd_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; bus.spi_csn = 1'b1; bus.spi_mosi = 1'b0;
    usb_pin = 1'b1; chan_pin = 1'b0; ws_pin = 1'b1; dd_pin = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge spi_clk);
    check_outs("reset_outs");
    check("reset_acc", acc_inc, 18'h0CCCC);
    check("reset_miso", bus.spi_miso, 0);
    check("reset_cfg_update", cfg_update, 0);
    rst = 1'b0;
    repeat (2) @(negedge spi_clk);

    spi_frame(1, 7'h06, 1, 0, 0);
    spi_frame(1, 7'h07, 1, 0, 0);

    wbuf[0] = 8'h34; wbuf[1] = 8'h12; wbuf[2] = 8'h03;
    spi_frame(0, 7'h00, 3, 0, 0);
    check("burst_acc", acc_inc, 18'h31234);

    dd_pin = 1'b1;
    wbuf[0] = 8'h00;
    spi_frame(0, 7'h06, 1, 0, 0);
    check("dith_disabled", dith_fact, 0);
    wbuf[0] = 8'h82;
    spi_frame(0, 7'h06, 1, 0, 0);
    usb_pin = 1'b1; chan_pin = 1'b1; ws_pin = 1'b1;
    #1;
    check("override_dith", dith_fact, 2);
    check("override_flags", {usb_i2sn, audio_chan_sel, i2s_ws_align}, 3'b000);

    wbuf[0] = 8'h55;
    spi_frame(0, 7'h00, 1, 0, 0);
    wbuf[0] = 8'h66; wbuf[1] = 8'h07;
    spi_frame(0, 7'h01, 2, 20, 0);
    check("abort_acc", acc_inc, 18'h31234);
    spi_frame(1, 7'h00, 2, 0, 0);

    wbuf[0] = 8'h5A;
    spi_frame(0, 7'h07, 1, 0, 0);
    wbuf[0] = 8'hFF;
    spi_frame(0, 7'h40, 1, 0, 0);
    spi_frame(1, 7'h7F, 2, 0, 0);

    wbuf[0] = 8'h0A; wbuf[1] = 8'h00;
    spi_frame(0, 7'h05, 2, 0, 12);
    check("rst_frame_dac", dac_ena, 5'h1F);

    for (int i = 0; i < 40; i++) begin
      bit rd;
      int addr, nb, stop;
      rd   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 9));
      nb   = $urandom_range(1, 4);
      stop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8 + 8 * nb - 1)) : 0;
      for (int j = 0; j < 16; j++) wbuf[j] = 8'($urandom);
      {usb_pin, chan_pin, ws_pin, dd_pin} = 4'($urandom_range(0, 15));
      spi_frame(rd, addr, nb, stop, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
